// File: rtl/pic_8259a_pkg.sv
// Shared encodings for the 8259A command-word sequencer: FSM states and
// the ICW1/OCW3 bit positions used when decoding CPU writes.
package pic_8259a_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } init_state_t;

    localparam int ICW1_IC4_BIT    = 0;
    localparam int ICW1_SNGL_BIT   = 1;
    localparam int ICW1_LTIM_BIT   = 3;
    localparam int ICW1_MARKER_BIT = 4;
    localparam int OCW3_SELECT_BIT = 3;

    function automatic logic is_wait_state(input init_state_t s);
        return (s == ST_WAIT_ICW2) || (s == ST_WAIT_ICW3) || (s == ST_WAIT_ICW4);
    endfunction

endpackage

// File: rtl/init_timeout_counter.sv
// Counts cycles spent waiting for the rest of an initialization sequence;
// flags expiry on the last allowed cycle. Built only with INIT_TIMEOUT_EN.
module init_timeout_counter #(
    parameter int CYCLES = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count;

    // Wraps at LAST so a write that beats expiry starts a fresh window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || !run || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/initialization_sequence_controller.sv
// Classifies 8259A CPU writes into ICW1-4 / OCW1-3 strobes and tracks the
// ICW sequence. Define INIT_TIMEOUT_EN to abort stalled sequences.
module initialization_sequence_controller
    import pic_8259a_pkg::*;
#(
    parameter int INIT_TIMEOUT_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       write_enable,
    input  logic       address_0,
    input  logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1,
    output logic       write_initial_command_word_2,
    output logic       write_initial_command_word_3,
    output logic       write_initial_command_word_4,
    output logic       write_operation_control_word_1,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic       single_or_cascade_config,
    output logic       level_or_edge_triggered_config,
    output logic       initialization_done,
    output logic       initialization_timeout
);

    init_state_t state;
    logic        ic4;
    logic        icw1_write;
    logic        a0_write;
    logic        ocw2_write;
    logic        ocw3_write;
    logic        timeout_expired;

    assign icw1_write = write_enable && !address_0 &&  internal_data_bus[ICW1_MARKER_BIT];
    assign a0_write   = write_enable &&  address_0;
    assign ocw2_write = write_enable && !address_0 && !internal_data_bus[ICW1_MARKER_BIT]
                        && !internal_data_bus[OCW3_SELECT_BIT];
    assign ocw3_write = write_enable && !address_0 && !internal_data_bus[ICW1_MARKER_BIT]
                        &&  internal_data_bus[OCW3_SELECT_BIT];

`ifdef INIT_TIMEOUT_EN
    logic timeout_pulse;

    init_timeout_counter #(
        .CYCLES (INIT_TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (icw1_write),
        .run     (is_wait_state(state)),
        .expired (timeout_expired)
    );

    assign initialization_timeout = timeout_pulse;
`else
    assign timeout_expired        = 1'b0;
    assign initialization_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                          <= ST_IDLE;
            ic4                            <= 1'b0;
            single_or_cascade_config       <= 1'b0;
            level_or_edge_triggered_config <= 1'b0;
            initialization_done            <= 1'b0;
            write_initial_command_word_1   <= 1'b0;
            write_initial_command_word_2   <= 1'b0;
            write_initial_command_word_3   <= 1'b0;
            write_initial_command_word_4   <= 1'b0;
            write_operation_control_word_1 <= 1'b0;
            write_operation_control_word_2 <= 1'b0;
            write_operation_control_word_3 <= 1'b0;
`ifdef INIT_TIMEOUT_EN
            timeout_pulse                  <= 1'b0;
`endif
        end else begin
            write_initial_command_word_1   <= 1'b0;
            write_initial_command_word_2   <= 1'b0;
            write_initial_command_word_3   <= 1'b0;
            write_initial_command_word_4   <= 1'b0;
            write_operation_control_word_1 <= 1'b0;
            write_operation_control_word_2 <= 1'b0;
            write_operation_control_word_3 <= 1'b0;
`ifdef INIT_TIMEOUT_EN
            timeout_pulse                  <= 1'b0;
`endif
            if (icw1_write) begin
                // ICW1 always (re)starts the sequence, whatever state we are in.
                state                          <= ST_WAIT_ICW2;
                initialization_done            <= 1'b0;
                write_initial_command_word_1   <= 1'b1;
                ic4                            <= internal_data_bus[ICW1_IC4_BIT];
                single_or_cascade_config       <= internal_data_bus[ICW1_SNGL_BIT];
                level_or_edge_triggered_config <= internal_data_bus[ICW1_LTIM_BIT];
            end else if (a0_write) begin
                case (state)
                    ST_WAIT_ICW2: begin
                        write_initial_command_word_2 <= 1'b1;
                        if (!single_or_cascade_config) begin
                            state <= ST_WAIT_ICW3;
                        end else if (ic4) begin
                            state <= ST_WAIT_ICW4;
                        end else begin
                            state               <= ST_READY;
                            initialization_done <= 1'b1;
                        end
                    end
                    ST_WAIT_ICW3: begin
                        write_initial_command_word_3 <= 1'b1;
                        if (ic4) begin
                            state <= ST_WAIT_ICW4;
                        end else begin
                            state               <= ST_READY;
                            initialization_done <= 1'b1;
                        end
                    end
                    ST_WAIT_ICW4: begin
                        write_initial_command_word_4 <= 1'b1;
                        state                        <= ST_READY;
                        initialization_done          <= 1'b1;
                    end
                    ST_READY: begin
                        write_operation_control_word_1 <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end else if (timeout_expired) begin
                // Dropped OCW-pattern writes do not count as progress.
                state <= ST_IDLE;
`ifdef INIT_TIMEOUT_EN
                timeout_pulse <= 1'b1;
`endif
            end else if (state == ST_READY) begin
                write_operation_control_word_2 <= ocw2_write;
                write_operation_control_word_3 <= ocw3_write;
            end
        end
    end

endmodule

// File: tb/tb_initialization_sequence_controller.sv
// Directed-vector bench for the 8259A command-word sequencer.
module tb_initialization_sequence_controller;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_ICW1 = 7'b1000000;
    localparam logic [6:0] S_ICW2 = 7'b0100000;
    localparam logic [6:0] S_ICW3 = 7'b0010000;
    localparam logic [6:0] S_ICW4 = 7'b0001000;
    localparam logic [6:0] S_OCW1 = 7'b0000100;
    localparam logic [6:0] S_OCW2 = 7'b0000010;
    localparam logic [6:0] S_OCW3 = 7'b0000001;

`ifdef INIT_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    typedef struct {
        string      name;
        logic       we;
        logic       a0;
        logic [7:0] data;
        logic [6:0] strobes;
        logic       sngl;
        logic       ltim;
        logic       done;
        logic       timeout;
    } vec_t;

    logic       clock;
    logic       reset_n;
    logic       write_enable;
    logic       address_0;
    logic [7:0] internal_data_bus;
    logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic       sngl, ltim, done, timeout;

    int tests    = 0;
    int failures = 0;
    vec_t vecs[$];

    initialization_sequence_controller #(
        .INIT_TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clock                          (clock),
        .reset_n                        (reset_n),
        .write_enable                   (write_enable),
        .address_0                      (address_0),
        .internal_data_bus              (internal_data_bus),
        .write_initial_command_word_1   (icw1),
        .write_initial_command_word_2   (icw2),
        .write_initial_command_word_3   (icw3),
        .write_initial_command_word_4   (icw4),
        .write_operation_control_word_1 (ocw1),
        .write_operation_control_word_2 (ocw2),
        .write_operation_control_word_3 (ocw3),
        .single_or_cascade_config       (sngl),
        .level_or_edge_triggered_config (ltim),
        .initialization_done            (done),
        .initialization_timeout         (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input string name, input logic we, input logic a0,
                                input logic [7:0] data, input logic [6:0] strobes,
                                input logic s, input logic l, input logic d,
                                input logic t);
        vec_t v;
        v.name = name; v.we = we; v.a0 = a0; v.data = data; v.strobes = strobes;
        v.sngl = s; v.ltim = l; v.done = d; v.timeout = t;
        return v;
    endfunction

    task automatic check(input string name, input logic [10:0] expected);
        logic [10:0] actual;
        actual = {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, sngl, ltim, done, timeout};
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %b expected %b (strobes1-4,ocw1-3,sngl,ltim,done,timeout)",
                     name, actual, expected);
        end
    endtask

    // One cycle per vector: inputs set on the falling edge, outputs sampled 1ns after rising.
    task automatic apply(input vec_t v);
        @(negedge clock);
        write_enable      = v.we;
        address_0         = v.a0;
        internal_data_bus = v.data;
        @(posedge clock);
        #1;
        write_enable = 1'b0;
        check(v.name, {v.strobes, v.sngl, v.ltim, v.done, v.timeout});
    endtask

    task automatic idle(input string name, input logic s, input logic l,
                        input logic d, input logic t);
        apply(mk(name, 1'b0, 1'b0, 8'h00, S_NONE, s, l, d, t));
    endtask

    initial begin
        reset_n           = 1'b0;
        write_enable      = 1'b0;
        address_0         = 1'b0;
        internal_data_bus = 8'h00;
        #1;
        check("reset_state", 11'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Writes before any ICW1 are dropped.
        apply(mk("idle_drop_a0",   1'b1, 1'b1, 8'h20, S_NONE, 0, 0, 0, 0));
        apply(mk("idle_drop_ocw2", 1'b1, 1'b0, 8'h20, S_NONE, 0, 0, 0, 0));

        vecs.push_back(mk("icw1_single_ic4", 1, 0, 8'h13, S_ICW1, 1, 0, 0, 0));
        vecs.push_back(mk("gap_wait_icw2",   0, 0, 8'h00, S_NONE, 1, 0, 0, 0));
        vecs.push_back(mk("icw2_single",     1, 1, 8'h20, S_ICW2, 1, 0, 0, 0));
        vecs.push_back(mk("icw4_single",     1, 1, 8'h01, S_ICW4, 1, 0, 1, 0));
        vecs.push_back(mk("ready_idle",      0, 0, 8'h00, S_NONE, 1, 0, 1, 0));
        vecs.push_back(mk("ocw1_ready",      1, 1, 8'hFF, S_OCW1, 1, 0, 1, 0));
        vecs.push_back(mk("ocw2_ready",      1, 0, 8'h20, S_OCW2, 1, 0, 1, 0));
        vecs.push_back(mk("ocw3_ready",      1, 0, 8'h0B, S_OCW3, 1, 0, 1, 0));
        vecs.push_back(mk("icw1_cascade",    1, 0, 8'h11, S_ICW1, 0, 0, 0, 0));
        vecs.push_back(mk("icw2_cascade",    1, 1, 8'h20, S_ICW2, 0, 0, 0, 0));
        vecs.push_back(mk("icw3_cascade",    1, 1, 8'h04, S_ICW3, 0, 0, 0, 0));
        vecs.push_back(mk("icw4_cascade",    1, 1, 8'h1D, S_ICW4, 0, 0, 1, 0));
        vecs.push_back(mk("icw1_ltim",       1, 0, 8'h1A, S_ICW1, 1, 1, 0, 0));
        vecs.push_back(mk("drop_ocw2_w2",    1, 0, 8'h20, S_NONE, 1, 1, 0, 0));
        vecs.push_back(mk("drop_ocw3_w2",    1, 0, 8'h08, S_NONE, 1, 1, 0, 0));
        vecs.push_back(mk("icw2_no_ic4",     1, 1, 8'h55, S_ICW2, 1, 1, 1, 0));
        vecs.push_back(mk("icw1_from_ready", 1, 0, 8'h13, S_ICW1, 1, 0, 0, 0));
        vecs.push_back(mk("icw2_mid",        1, 1, 8'h20, S_ICW2, 1, 0, 0, 0));
        vecs.push_back(mk("icw1_restart",    1, 0, 8'h13, S_ICW1, 1, 0, 0, 0));
        vecs.push_back(mk("drop_after_rst",  1, 0, 8'h20, S_NONE, 1, 0, 0, 0));
        vecs.push_back(mk("icw2_after_rst",  1, 1, 8'h30, S_ICW2, 1, 0, 0, 0));
        vecs.push_back(mk("icw4_after_rst",  1, 1, 8'h01, S_ICW4, 1, 0, 1, 0));
        vecs.push_back(mk("icw1_casc_noic4", 1, 0, 8'h10, S_ICW1, 0, 0, 0, 0));
        vecs.push_back(mk("icw2_casc_noic4", 1, 1, 8'h20, S_ICW2, 0, 0, 0, 0));
        vecs.push_back(mk("icw3_to_ready",   1, 1, 8'h04, S_ICW3, 0, 0, 1, 0));
        vecs.push_back(mk("ocw3_after_icw3", 1, 0, 8'h0A, S_OCW3, 0, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Asynchronous reset in the middle of a sequence with a write pending.
        apply(mk("icw1_pre_reset", 1, 0, 8'h1B, S_ICW1, 1, 1, 0, 0));
        @(negedge clock);
        write_enable      = 1'b1;
        address_0         = 1'b1;
        internal_data_bus = 8'h20;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_clear", 11'b0);
        @(posedge clock);
        #1;
        check("reset_held", 11'b0);
        write_enable = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        apply(mk("post_reset_drop", 1, 1, 8'h20, S_NONE, 0, 0, 0, 0));

`ifdef INIT_TIMEOUT_EN
        apply(mk("to_icw1", 1, 0, 8'h13, S_ICW1, 1, 0, 0, 0));
        for (int i = 0; i < 15; i++) idle("to_wait", 1, 0, 0, 0);
        idle("to_pulse", 1, 0, 0, 1);
        idle("to_pulse_end", 1, 0, 0, 0);
        apply(mk("to_idle_drop", 1, 1, 8'h20, S_NONE, 1, 0, 0, 0));
        apply(mk("race_icw1", 1, 0, 8'h13, S_ICW1, 1, 0, 0, 0));
        for (int i = 0; i < 15; i++) idle("race_wait", 1, 0, 0, 0);
        apply(mk("race_icw2_wins", 1, 1, 8'h20, S_ICW2, 1, 0, 0, 0));
        apply(mk("race_icw4", 1, 1, 8'h01, S_ICW4, 1, 0, 1, 0));
`else
        apply(mk("nto_icw1", 1, 0, 8'h13, S_ICW1, 1, 0, 0, 0));
        for (int i = 0; i < 40; i++) idle("nto_wait", 1, 0, 0, 0);
        apply(mk("nto_icw2", 1, 1, 8'h20, S_ICW2, 1, 0, 0, 0));
        apply(mk("nto_icw4", 1, 1, 8'h01, S_ICW4, 1, 0, 1, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
